// File: rtl/if_stage.sv
// Instruction-fetch stage: architectural PC plus the IF/ID pipeline register.
// Optional macro IF_MISALIGN_CHECK_EN adds a sticky misaligned-redirect flag (misalign_f).
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_f,
  input  logic        stall_d,
  input  logic        flush_d,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_f,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pcplus4_d,
  output logic        valid_d
`ifdef IF_MISALIGN_CHECK_EN
  ,
  output logic        misalign_f
`endif
);

  logic [31:0] pcplus4_f;
  logic [31:0] redirect_tgt;
  logic [31:0] pc_next;

  assign pcplus4_f = pc_f + 32'd4;
  assign imem_addr = pc_f;

`ifdef IF_MISALIGN_CHECK_EN
  assign redirect_tgt = {redirect_pc[31:2], 2'b00};
`else
  assign redirect_tgt = redirect_pc;
`endif

  // Redirect wins over a fetch stall so a resolved branch is never lost.
  always_comb begin
    pc_next = pcplus4_f;
    if (redirect) begin
      pc_next = redirect_tgt;
    end else if (stall_f) begin
      pc_next = pc_f;
    end
  end

  // ---- IF stage: PC register ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_f <= RESET_PC;
    end else begin
      pc_f <= pc_next;
    end
  end

  // ---- IF/ID boundary: the word fetched in a redirect cycle is wrong-path ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr_d   <= NOP_INSTR;
      pc_d      <= 32'd0;
      pcplus4_d <= 32'd0;
      valid_d   <= 1'b0;
    end else if (flush_d || redirect) begin
      instr_d   <= NOP_INSTR;
      pc_d      <= 32'd0;
      pcplus4_d <= 32'd0;
      valid_d   <= 1'b0;
    end else if (!stall_d) begin
      instr_d   <= imem_rdata;
      pc_d      <= pc_f;
      pcplus4_d <= pcplus4_f;
      valid_d   <= 1'b1;
    end
  end

`ifdef IF_MISALIGN_CHECK_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      misalign_f <= 1'b0;
    end else if (redirect && (redirect_pc[1:0] != 2'b00)) begin
      misalign_f <= 1'b1;
    end
  end
`endif

endmodule
